// File: rtl/masked_sbox_pkg.sv
// Shared constants, state encoding and core request payload for the masked S-box feeder.
package masked_sbox_pkg;

    localparam int unsigned LFSR_W       = 32;
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

    localparam logic [1:0] OP_FWD = 2'b00;
    localparam logic [1:0] OP_INV = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] prd;
        logic [7:0] mask;
        logic [7:0] data;
    } sb_req_t;

endpackage

// File: rtl/share_lfsr.sv
// Free-running Galois LFSR supplying mask and fresh randomness bits.
// Reseed port present only with MASKED_SBOX_FEEDER_RESEED_EN.
module share_lfsr
    import masked_sbox_pkg::*;
#(
    parameter int unsigned   W    = LFSR_W,
    parameter logic [W-1:0]  SEED = W'(DEFAULT_SEED)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
`ifdef MASKED_SBOX_FEEDER_RESEED_EN
    input  logic         load,
    input  logic [W-1:0] seed_val,
`endif
    output logic [15:0]  rnd
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_n;

    always_comb begin
        lfsr_n = lfsr_q;
        if (step) begin
            lfsr_n = (lfsr_q >> 1) ^ (lfsr_q[0] ? W'(LFSR_POLY) : '0);
        end
`ifdef MASKED_SBOX_FEEDER_RESEED_EN
        // A zero seed would lock the LFSR, so fall back to the reset seed.
        if (load) begin
            lfsr_n = (seed_val == '0) ? SEED : seed_val;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_n;
        end
    end

    assign rnd = lfsr_q[15:0];

endmodule

// File: rtl/masked_sbox_feeder.sv
// Masks input bytes, drives the masked S-box core for its fixed latency, and returns the share pair.
// Optional LFSR reseed ports under MASKED_SBOX_FEEDER_RESEED_EN.
module masked_sbox_feeder
    import masked_sbox_pkg::*;
#(
    parameter int unsigned      SBOX_LAT = 3,
    parameter int unsigned      LFSR_W   = 32,
    parameter logic [31:0]      SEED     = 32'hACE1_2468
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_data_i,
    input  logic [1:0]        in_op_i,
    output logic [7:0]        sb_data_o,
    output logic [7:0]        sb_mask_o,
    output logic [1:0]        sb_op_o,
    output logic [7:0]        sb_prd_o,
    input  logic [7:0]        sb_data_i,
    input  logic [7:0]        sb_mask_i,
`ifdef MASKED_SBOX_FEEDER_RESEED_EN
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
`endif
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        out_data_o,
    output logic [7:0]        out_mask_o
);

    localparam int unsigned CNT_W = 4;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    sb_req_t          sb_q, sb_n;
    logic [7:0]       out_data_q, out_data_n;
    logic [7:0]       out_mask_q, out_mask_n;
    logic             out_valid_q, out_valid_n;
    logic             in_ready_q, in_ready_n;
    logic [15:0]      rnd;

    share_lfsr #(
        .W    (LFSR_W),
        .SEED (LFSR_W'(SEED))
    ) u_lfsr (
        .clk      (clk_i),
        .rst      (rst_i),
        .step     (1'b1),
`ifdef MASKED_SBOX_FEEDER_RESEED_EN
        .load     (seed_load_i),
        .seed_val (seed_i),
`endif
        .rnd      (rnd)
    );

    // Next-state and output logic; the plain input byte only ever enters a register XORed with the mask.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        sb_n       = sb_q;
        out_data_n = out_data_q;
        out_mask_n = out_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    sb_n.data = in_data_i ^ rnd[7:0];
                    sb_n.mask = rnd[7:0];
                    sb_n.op   = in_op_i;
                    sb_n.prd  = rnd[15:8];
                    cnt_n     = CNT_W'(SBOX_LAT);
                    state_n   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_data_n = sb_data_i;
                    out_mask_n = sb_mask_i;
                    sb_n       = '0;
                    state_n    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        in_ready_n  = (state_n == ST_IDLE);
        out_valid_n = (state_n == ST_HOLD);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sb_q        <= '0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            sb_q        <= sb_n;
            out_data_q  <= out_data_n;
            out_mask_q  <= out_mask_n;
            out_valid_q <= out_valid_n;
            in_ready_q  <= in_ready_n;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_mask_o  = out_mask_q;
    assign sb_data_o   = sb_q.data;
    assign sb_mask_o   = sb_q.mask;
    assign sb_op_o     = sb_q.op;
    assign sb_prd_o    = sb_q.prd;

endmodule

// File: doc/masked_sbox_feeder.md
Name: masked_sbox_feeder

Overview:
- Front-end and back-end stage around the masked Canright S-box core.
- Accepts an unmasked byte and an op code over valid/ready, splits the byte into two Boolean shares using a fresh mask from an internal LFSR, and supplies 8 fresh bits on the core's randomness input.
- Holds all core inputs stable for the core's fixed pipeline latency, then captures the output share pair and presents it downstream over valid/ready.
- Result shares are never recombined inside this block.

Parameters:
- SBOX_LAT, 3, pipeline latency of the masked S-box core in cycles (legal range 1..15).
- LFSR_W, 32, LFSR width (fixed at 32; the polynomial is defined only for 32).
- SEED, 32'hACE1_2468, LFSR reset value; must be nonzero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- in_valid_i  in  1  input byte valid
- in_ready_o  out  1  block can accept an input byte
- in_data_i  in  8  unmasked input byte
- in_op_i  in  2  S-box op code (00 forward, 01 inverse, others passed through unchanged)
- sb_data_o  out  8  masked share to the core (x ^ m)
- sb_mask_o  out  8  mask share to the core (m)
- sb_op_o  out  2  op code to the core
- sb_prd_o  out  8  fresh randomness to the core
- sb_data_i  in  8  masked result share from the core
- sb_mask_i  in  8  mask result share from the core
- out_valid_o  out  1  result shares valid
- out_ready_i  in  1  downstream accepts the result
- out_data_o  out  8  result share 0
- out_mask_o  out  8  result share 1

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State = IDLE; LFSR = SEED; counter = 0.
  - in_ready_o=1.
  - out_valid_o=0; out_data_o and out_mask_o = 0.
  - All sb_* outputs = 0.
  - Reset mid-operation abandons the transaction with no output.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, taps mask 32'h8020_0003.
  - Advances one step on every clock edge, regardless of state.
  - Mask m = lfsr[7:0]; prd = lfsr[15:8]. Both are sampled from the current (pre-advance) value on the accept edge.
- State machine states: IDLE, BUSY, HOLD.
- IDLE:
  - in_ready_o=1.
  - If in_valid_i=1, accept on that edge and register:
    - sb_data_o = in_data_i ^ m
    - sb_mask_o = m
    - sb_op_o = in_op_i
    - sb_prd_o = prd
  - Load counter = SBOX_LAT and go to BUSY.
- BUSY:
  - in_ready_o=0; all sb_* outputs held constant.
  - Counter decrements each edge.
  - On the edge where counter==1: capture sb_data_i into out_data_o and sb_mask_i into out_mask_o; clear all sb_* outputs to 0; go to HOLD.
  - Capture therefore happens SBOX_LAT edges after the accept edge.
  - out_valid_o rises in the cycle after capture, SBOX_LAT+1 cycles after the accept cycle.
- HOLD:
  - out_valid_o=1; out_data_o and out_mask_o stable until the handshake completes.
  - On an edge with out_ready_i=1: out_valid_o=0, go to IDLE. out_data_o and out_mask_o keep their last value; only out_valid_o qualifies them.
  - in_ready_o=0 in HOLD. Throughput is one byte per SBOX_LAT+2 cycles minimum.
- Transitions: at most one per edge. in_valid_i is ignored outside IDLE.
- Security rules:
  - The unmasked in_data_i is never stored in any register.
  - No combinational path exists from in_data_i to any output.

Optional Feature:
- Macro: MASKED_SBOX_FEEDER_RESEED_EN.
- When defined, add two ports:
  - seed_load_i  in  1
  - seed_i  in  32
- A seed_load_i=1 edge loads the LFSR with seed_i instead of advancing it. If seed_i==0, SEED is loaded instead.
- seed_load_i has priority over the accept edge's LFSR advance. The accept still uses the pre-load LFSR value.
- When the macro is undefined, these ports are absent and the LFSR only advances.

Decomposition:
- Package masked_sbox_pkg holds:
  - LFSR_POLY constant
  - default SEED constant
  - op code constants OP_FWD=2'b00 and OP_INV=2'b01
  - state typedef for IDLE/BUSY/HOLD
- One sub-module, share_lfsr: 32-bit Galois LFSR with reset seed, step input, and (under the macro) load port.

Test Plan:
- Reset, then in_data_i=8'h00, op 00 with a behavioural core model (AES S-box remasked, delay SBOX_LAT=3) -> out_valid_o high 4 cycles after accept; out_data_o^out_mask_o=8'h63.
- in_data_i=8'h53, op 00 -> recombined result 8'hED. During BUSY: sb_data_o^sb_mask_o=8'h53, and sb_mask_o equals bits [7:0] of the bench LFSR model.
- in_data_i=8'h63, op 01 -> recombined result 8'h00. sb_op_o=01 held stable for all 3 BUSY cycles.
- Hold out_ready_i=0 for 10 cycles in HOLD:
  - out_valid_o and the result shares stay stable; in_ready_o=0.
  - A second in_valid_i offered meanwhile is not accepted until 1 cycle after the out handshake.
- Assert rst_i in the 2nd BUSY cycle -> same cycle: sb_* = 0, out_valid_o=0, in_ready_o=1. After release, LFSR restarts from 32'hACE1_2468.
- With the macro defined: seed_load_i=1, seed_i=0 -> LFSR equals SEED. Back-to-back accepts of 8'h00 yield different sb_mask_o values.
